// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: multiplexed common-anode 7-segment scanner with a
// double-buffered hex / keycode-note display, blanking, decimal points and PWM brightness.
module seg7_scan_driver #(
  parameter int N_DIGITS     = 8,
  parameter int DIV_BITS     = 17,
  parameter int BLANK_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic [4*N_DIGITS-1:0] data_in,
  input  logic [N_DIGITS-1:0]   dp_in,
  input  logic [N_DIGITS-1:0]   blank_mask,
  input  logic                  mode,
  input  logic                  load,
  input  logic [3:0]            bright,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [N_DIGITS-1:0]   an,
  output logic                  pending,
  output logic                  frame_done
);

  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int PW    = DIV_BITS + 5;
  localparam logic [PW-1:0] ON_SPAN   = PW'((32'd1 << DIV_BITS) - BLANK_CYCLES);
  localparam logic [PW-1:0] BLANK_EXT = PW'(BLANK_CYCLES);
  localparam logic [N_DIGITS-1:0] AN_ONE = {{(N_DIGITS-1){1'b0}}, 1'b1};

  logic [DIV_BITS-1:0]   cnt_r;
  logic [IDX_W-1:0]      idx_r;
  logic [4*N_DIGITS-1:0] act_data_r, pend_data_r;
  logic [N_DIGITS-1:0]   act_dp_r, pend_dp_r;
  logic [N_DIGITS-1:0]   act_blank_r, pend_blank_r;
  logic                  act_mode_r, pend_mode_r;
  logic                  pending_r;
  logic [6:0]            seg_r;
  logic                  dp_r;
  logic [N_DIGITS-1:0]   an_r;
  logic                  frame_done_r;

  logic                  wrap_s, frame_s, in_win_s, lit_s;
  logic [PW-1:0]         bright_ext_s, on_prod_s, win_end_s, cnt_ext_s;
  logic [IDX_W-1:0]      byte_idx_s;
  logic [7:0]            note_byte_s;
  logic [3:0]            nib_s;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    case (nib)
      4'h0: hex_to_seg = 7'h40;
      4'h1: hex_to_seg = 7'h79;
      4'h2: hex_to_seg = 7'h24;
      4'h3: hex_to_seg = 7'h30;
      4'h4: hex_to_seg = 7'h19;
      4'h5: hex_to_seg = 7'h12;
      4'h6: hex_to_seg = 7'h02;
      4'h7: hex_to_seg = 7'h78;
      4'h8: hex_to_seg = 7'h00;
      4'h9: hex_to_seg = 7'h10;
      4'hA: hex_to_seg = 7'h08;
      4'hB: hex_to_seg = 7'h03;
      4'hC: hex_to_seg = 7'h46;
      4'hD: hex_to_seg = 7'h21;
      4'hE: hex_to_seg = 7'h06;
      4'hF: hex_to_seg = 7'h0E;
      default: hex_to_seg = 7'h7F;
    endcase
  endfunction

  // PS/2 set-2 keycode to {row, note}; unknown codes read as 00
  function automatic logic [7:0] key_to_note(input logic [7:0] code);
    case (code)
      8'h15: key_to_note = 8'h11;
      8'h1D: key_to_note = 8'h12;
      8'h24: key_to_note = 8'h13;
      8'h2D: key_to_note = 8'h14;
      8'h2C: key_to_note = 8'h15;
      8'h35: key_to_note = 8'h16;
      8'h3C: key_to_note = 8'h17;
      8'h1C: key_to_note = 8'h21;
      8'h1B: key_to_note = 8'h22;
      8'h23: key_to_note = 8'h23;
      8'h2B: key_to_note = 8'h24;
      8'h34: key_to_note = 8'h25;
      8'h33: key_to_note = 8'h26;
      8'h3B: key_to_note = 8'h27;
      8'h1A: key_to_note = 8'h31;
      8'h22: key_to_note = 8'h32;
      8'h21: key_to_note = 8'h33;
      8'h2A: key_to_note = 8'h34;
      8'h32: key_to_note = 8'h35;
      8'h31: key_to_note = 8'h36;
      8'h3A: key_to_note = 8'h37;
      default: key_to_note = 8'h00;
    endcase
  endfunction

  // Scan position flags: slot wrap and frame boundary
  always_comb begin
    wrap_s  = (cnt_r == {DIV_BITS{1'b1}});
    frame_s = wrap_s && (idx_r == IDX_W'(N_DIGITS - 1));
  end

  // Slot counter and digit index
  always_ff @(posedge clk) begin
    if (clr) begin
      cnt_r <= '0;
      idx_r <= '0;
    end else begin
      cnt_r <= cnt_r + DIV_BITS'(1);
      if (frame_s) begin
        idx_r <= '0;
      end else if (wrap_s) begin
        idx_r <= idx_r + IDX_W'(1);
      end else begin
        idx_r <= idx_r;
      end
    end
  end

  // Pending/active double buffer; the commit uses the buffer as it stood before this edge's load
  always_ff @(posedge clk) begin
    if (clr) begin
      pend_data_r  <= '0;
      pend_dp_r    <= '0;
      pend_blank_r <= '0;
      pend_mode_r  <= 1'b0;
      act_data_r   <= '0;
      act_dp_r     <= '0;
      act_blank_r  <= '0;
      act_mode_r   <= 1'b0;
      pending_r    <= 1'b0;
    end else begin
      if (frame_s && pending_r) begin
        act_data_r  <= pend_data_r;
        act_dp_r    <= pend_dp_r;
        act_blank_r <= pend_blank_r;
        act_mode_r  <= pend_mode_r;
      end
      if (load) begin
        pend_data_r  <= data_in;
        pend_dp_r    <= dp_in;
        pend_blank_r <= blank_mask;
        pend_mode_r  <= mode;
        pending_r    <= 1'b1;
      end else if (frame_s) begin
        pending_r <= 1'b0;
      end else begin
        pending_r <= pending_r;
      end
    end
  end

  // Brightness window and nibble selection for the current scan position
  always_comb begin
    bright_ext_s = PW'(bright) + PW'(1);
    on_prod_s    = bright_ext_s * ON_SPAN;
    win_end_s    = BLANK_EXT + (on_prod_s >> 4);
    cnt_ext_s    = PW'(cnt_r);
    in_win_s     = (cnt_ext_s >= BLANK_EXT) && (cnt_ext_s < win_end_s);
    lit_s        = in_win_s && !act_blank_r[idx_r];
    byte_idx_s   = idx_r >> 1;
    note_byte_s  = key_to_note(act_data_r[{byte_idx_s, 3'b000} +: 8]);
    if (act_mode_r) begin
      if (idx_r[0]) begin
        nib_s = note_byte_s[7:4];
      end else begin
        nib_s = note_byte_s[3:0];
      end
    end else begin
      nib_s = act_data_r[{idx_r, 2'b00} +: 4];
    end
  end

  // Registered display drive and frame pulse
  always_ff @(posedge clk) begin
    if (clr) begin
      an_r         <= '1;
      seg_r        <= 7'h7F;
      dp_r         <= 1'b1;
      frame_done_r <= 1'b0;
    end else begin
      frame_done_r <= frame_s;
      if (lit_s) begin
        an_r  <= ~(AN_ONE << idx_r);
        seg_r <= hex_to_seg(nib_s);
        dp_r  <= ~act_dp_r[idx_r];
      end else begin
        an_r  <= '1;
        seg_r <= 7'h7F;
        dp_r  <= 1'b1;
      end
    end
  end

  assign seg        = seg_r;
  assign dp         = dp_r;
  assign an         = an_r;
  assign pending    = pending_r;
  assign frame_done = frame_done_r;

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Parametrised successor to the team's 8-digit hex scan driver for the board's multiplexed common-anode 7-segment display.
- Displays N_DIGITS nibbles in two modes: raw hex, or PS/2 set-2 keycode to row/note (keyboard-synth note display).
- Adds per-digit blanking and decimal points, PWM brightness, and anti-ghost blank intervals.
- Double-buffered load with a strobe; new data commits only at a frame boundary, so a frame never mixes two values.

Parameters:
- N_DIGITS, 8, number of digits/anodes; must be even.
- DIV_BITS, 17, width of the slot counter; each digit slot lasts 2^DIV_BITS clocks.
- BLANK_CYCLES, 64, all-anodes-off cycles at the start of every slot; must be less than 2^DIV_BITS.

Ports:
- clk, in, 1, system clock.
- clr, in, 1, synchronous active-high reset.
- data_in, in, 4*N_DIGITS, display word; digit 0 = data_in[3:0].
- dp_in, in, N_DIGITS, per-digit decimal point, 1 = lit.
- blank_mask, in, N_DIGITS, 1 = digit dark.
- mode, in, 1, 0 = hex, 1 = keycode-note.
- load, in, 1, one-cycle strobe; captures data_in, dp_in, blank_mask and mode into the pending buffer.
- bright, in, 4, brightness 0..15, sampled live.
- seg, out, 7, gfedcba, active-low.
- dp, out, 1, active-low.
- an, out, N_DIGITS, active-low anodes.
- pending, out, 1, pending buffer not yet committed.
- frame_done, out, 1, one-cycle pulse at each frame boundary.

Behaviour:
- Reset (clr sampled high at a clk edge). The next edge holds: cnt=0, idx=0, active and pending buffers=0, pending=0, an=all 1, seg=7'h7F, dp=1, frame_done=0. clr asserted mid-slot behaves the same way; a pending load is discarded.
- Slot counter: cnt increments every clock and wraps at 2^DIV_BITS-1.
  - On wrap, idx increments.
  - When the wrap happens with idx=N_DIGITS-1, idx goes to 0 instead. That is the frame boundary.
- Frame boundary, same edge as the wrap:
  - frame_done=1 for one cycle.
  - If pending=1, active <= pending buffer and pending <= 0.
- Load:
  - load=1 copies the inputs to the pending buffer and sets pending=1.
  - A second load before the boundary overwrites the buffer; the last load wins.
  - A load on the boundary cycle is captured into the buffer and stays pending until the next boundary. The commit on that edge uses the old buffer contents.
- On-window:
  - on_len = ((bright+1)*(2^DIV_BITS-BLANK_CYCLES))>>4.
  - Digit idx is lit when BLANK_CYCLES <= cnt < BLANK_CYCLES+on_len and active blank_mask[idx]=0.
  - When lit, an[idx]=0 and all other anodes are 1. Otherwise an is all 1.
- Outputs:
  - seg, dp and an are registered, so they reflect the cnt/idx of the previous cycle (1-cycle latency).
  - dp = ~active dp_in[idx] while lit; otherwise dp=1.
  - seg shows the decoded nibble of idx while lit; otherwise 7'h7F.
- Hex decode, nibble to seg:
  - 0:40, 1:79, 2:24, 3:30, 4:19, 5:12, 6:02, 7:78
  - 8:00, 9:10, A:08, B:03, C:46, D:21, E:06, F:0E
- Keycode-note mode: byte k of the active data becomes digit 2k = note and digit 2k+1 = row. The byte is translated before the nibble split.
  - Row 1: 15→11, 1D→12, 24→13, 2D→14, 2C→15, 35→16, 3C→17.
  - Row 2: 1C→21, 1B→22, 23→23, 2B→24, 34→25, 33→26, 3B→27.
  - Row 3: 1A→31, 22→32, 21→33, 2A→34, 32→35, 31→36, 3A→37.
  - Any other byte → 00.
- Mode is part of the buffered load, so a mode change also takes effect only at a frame boundary.

Test Plan (N_DIGITS=4, DIV_BITS=6, BLANK_CYCLES=4; slot = 64 cycles, frame = 256 cycles):
- Reset: clr high for 3 cycles, then low → an=4'hF, seg=7'h7F, dp=1, pending=0. an=4'b1110 first appears on the edge after cnt=4 of the first slot.
- Hex commit: at cycle 10 set data_in=16'h1234, mode=0, bright=15, load pulse → pending=1 until cycle 256. At cycle 256 frame_done=1 and pending=0. In the next frame, an=1110 with seg=7'h19 (digit "4"); an=0111 with seg=7'h79 (digit "1").
- Keycode mode: load data_in=16'h1A15, mode=1 → after commit digits 0..3 show 1,1,1,3. Then load 16'hFF15 → digits show 1,1,0,0.
- Brightness: bright=0 → each anode low for exactly 3 cycles per slot (cnt 4..6 plus 1 latency). bright=7 → 30 cycles. bright=15 → 60 cycles. No anode is low while cnt<4.
- Mask/dp: blank_mask=4'b0010, dp_in=4'b0001 → an[1] is never 0; dp=0 only while an[0]=0.
- Races: two loads (16'hAAAA then 16'hBBBB) within one frame → only B is displayed. A load on the boundary cycle is shown one frame later. clr asserted at cnt=30 → reset state on the next edge and the pending load is lost.
